// File: rtl/lab_nios_multi_timer_pkg.sv
// Shared constants and types for the multi-channel interval timer.
package lab_nios_multi_timer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OFF_W  = 3;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD_L = 3'd2;
  localparam logic [2:0] OFF_PERIOD_H = 3'd3;
  localparam logic [2:0] OFF_SNAP_L   = 3'd4;
  localparam logic [2:0] OFF_SNAP_H   = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;

  localparam int unsigned STATUS_TO  = 0;
  localparam int unsigned STATUS_RUN = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  typedef struct packed {
    logic stop;
    logic start;
    logic cont;
    logic ito;
  } ctrl_t;

endpackage

// File: rtl/lab_nios_multi_timer_if.sv
// Avalon-MM slave bus plus interrupt outputs of the timer block.
interface lab_nios_multi_timer_if
  import lab_nios_multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned AW = OFF_W + $clog2(NUM_CH);

  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq_vec, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq_vec, irq
  );
endinterface

// File: rtl/lab_nios_multi_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags and its register file.
module lab_nios_multi_timer_channel
  import lab_nios_multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned PRESCALE_W     = 16,
  parameter int unsigned DEFAULT_PERIOD = 99999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_word_c,
  output logic              irq_c
);
  localparam int unsigned HI_W = CNT_W - 16;

  logic [CNT_W-1:0]      period_q, period_d, count_q, count_d, snap_q, snap_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic                  run_q, run_d, to_q, to_d, reload_q, reload_d;
  logic                  tick, timeout;

  // Next-state: tick/counter first, then bus writes, then TO set and forced reload override.
  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    snap_d   = snap_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    ctrl_d   = ctrl_q;
    run_d    = run_q;
    to_d     = to_q;
    reload_d = 1'b0;
    tick     = run_q && (pcnt_q == '0);
    timeout  = tick && (count_q == '0) && !reload_q;

    if (run_q) pcnt_d = tick ? presc_q : pcnt_q - PRESCALE_W'(1);

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = period_q;
        if (!ctrl_q.cont) run_d = 1'b0;
      end
    end

    if (we) begin
      case (offset)
        OFF_STATUS:   to_d = 1'b0;
        OFF_CONTROL: begin
          ctrl_d = ctrl_t'(wdata[3:0]);
          if (wdata[CTRL_STOP]) run_d = 1'b0;
          if (wdata[CTRL_START]) begin
            run_d  = 1'b1;
            pcnt_d = presc_q;
          end
        end
        OFF_PERIOD_L: begin
          period_d[15:0] = wdata;
          reload_d       = 1'b1;
        end
        OFF_PERIOD_H: begin
          period_d[CNT_W-1:16] = wdata[HI_W-1:0];
          reload_d             = 1'b1;
        end
        OFF_SNAP_L, OFF_SNAP_H: snap_d = count_q;
        OFF_PRESCALE: presc_d = wdata[PRESCALE_W-1:0];
        default: ;
      endcase
    end

    if (timeout) to_d = 1'b1;

    // A period write stops the channel and reloads both counters one cycle later.
    if (reload_q) begin
      count_d = period_q;
      pcnt_d  = presc_q;
      run_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= CNT_W'(DEFAULT_PERIOD);
      count_q  <= CNT_W'(DEFAULT_PERIOD);
      snap_q   <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      ctrl_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      ctrl_q   <= ctrl_d;
      run_q    <= run_d;
      to_q     <= to_d;
      reload_q <= reload_d;
    end
  end

  // Register read word for the addressed offset.
  always_comb begin
    rd_word_c = '0;
    case (offset)
      OFF_STATUS: begin
        rd_word_c[STATUS_RUN] = run_q;
        rd_word_c[STATUS_TO]  = to_q;
      end
      OFF_CONTROL:  rd_word_c[3:0] = ctrl_q;
      OFF_PERIOD_L: rd_word_c = period_q[15:0];
      OFF_PERIOD_H: rd_word_c = 16'(period_q[CNT_W-1:16]);
      OFF_SNAP_L:   rd_word_c = snap_q[15:0];
      OFF_SNAP_H:   rd_word_c = 16'(snap_q[CNT_W-1:16]);
      OFF_PRESCALE: rd_word_c = 16'(presc_q);
      default:      rd_word_c = '0;
    endcase
  end

  assign irq_c = to_q & ctrl_q.ito;

endmodule

// File: rtl/lab_nios_multi_timer.sv
// Multi-channel interval timer: address decode, channel array, read mux and irq combine.
module lab_nios_multi_timer
  import lab_nios_multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned PRESCALE_W     = 16,
  parameter int unsigned DEFAULT_PERIOD = 99999
) (
  input  logic                  clk,
  input  logic                  reset,
  lab_nios_multi_timer_if.slave bus
);
  logic [3:0]        ch_sel;
  logic [2:0]        offset;
  logic              wr;
  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] irq_vec_c;
  logic [DATA_W-1:0] rd_word [NUM_CH];
  logic [DATA_W-1:0] readdata_q, readdata_d;

  assign ch_sel = 4'(bus.address >> OFF_W);
  assign offset = bus.address[2:0];
  assign wr     = bus.chipselect & ~bus.write_n;

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    assign we[i] = wr && (ch_sel == 4'(i));

    lab_nios_multi_timer_channel #(
      .CNT_W          (CNT_W),
      .PRESCALE_W     (PRESCALE_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .we        (we[i]),
      .offset    (offset),
      .wdata     (bus.writedata),
      .rd_word_c (rd_word[i]),
      .irq_c     (irq_vec_c[i])
    );
  end

  // Out-of-range channel indices read as zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch_sel == 4'(i)) readdata_d = rd_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq_vec  = irq_vec_c;
  assign bus.irq      = |irq_vec_c;

endmodule

// File: tb/tb_lab_nios_multi_timer.sv
// Self-checking bench: reset register table, directed corner sequences, randomized timing runs.
module tb_lab_nios_multi_timer;
  localparam int unsigned NUM_CH = 5;
  localparam int unsigned AW     = 3 + $clog2(NUM_CH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lab_nios_multi_timer_if #(.NUM_CH(NUM_CH)) bus ();

  lab_nios_multi_timer #(.NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          ch;
    int          off;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int ch, input int off, input logic [15:0] exp, input string name);
    vec_t v;
    v.ch = ch; v.off = off; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input int off, input logic [15:0] d, input bit w);
    bus.address    = AW'((ch << 3) | off);
    bus.chipselect = 1'b1;
    bus.write_n    = ~w;
    bus.writedata  = d;
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wr(input int ch, input int off, input logic [15:0] d);
    drive(ch, off, d, 1'b1);
    cyc();
    idle();
  endtask

  task automatic rd(input int ch, input int off, output logic [15:0] d);
    drive(ch, off, 16'h0, 1'b0);
    cyc();
    d = bus.readdata;
    idle();
  endtask

  task automatic do_reset();
    drive(0, 2, 16'h0, 1'b0);
    idle();
    reset = 1'b1;
    cyc();
    check("rst_irq_first_edge", 32'(bus.irq), 32'(0));
    cyc();
    check("rst_readdata", 32'(bus.readdata), 32'(0));
    check("rst_irq_vec", 32'(bus.irq_vec), 32'(0));
    reset = 1'b0;
  endtask

  task automatic prog(input int ch, input int p, input int s, input logic [15:0] ctrl);
    wr(ch, 2, 16'(p));
    wr(ch, 3, 16'(p >> 16));
    wr(ch, 6, 16'(s));
    cyc();
    wr(ch, 1, ctrl);
  endtask

  // Continuous mode: an event every (P+1)*(S+1) cycles; TO is cleared on the cycle after each event.
  task automatic run_cont(input int ch, input int p, input int s, input int ncyc);
    int l;
    bit to_m;
    bit clr;
    l    = (p + 1) * (s + 1);
    to_m = 1'b0;
    do_reset();
    prog(ch, p, s, 16'h7);
    for (int t = 1; t <= ncyc; t++) begin
      clr = to_m;
      if (clr) drive(ch, 0, 16'h0, 1'b1);
      else     idle();
      cyc();
      if (clr) to_m = 1'b0;
      if (t % l == 0) to_m = 1'b1;
      check($sformatf("cont_irq_ch%0d_p%0d_s%0d_t%0d", ch, p, s, t), 32'(bus.irq_vec[ch]), 32'(to_m));
    end
    idle();
    check($sformatf("cont_irq_or_ch%0d", ch), 32'(bus.irq), 32'(to_m));
  endtask

  // One-shot: TO sets (P+1)*(S+1) cycles after START, channel stops with counter back at PERIOD.
  task automatic run_one(input int ch, input int p, input int s);
    int l;
    logic [15:0] d;
    l = (p + 1) * (s + 1);
    do_reset();
    prog(ch, p, s, 16'h5);
    for (int t = 1; t <= l + 3; t++) begin
      cyc();
      check($sformatf("one_irq_ch%0d_p%0d_s%0d_t%0d", ch, p, s, t), 32'(bus.irq_vec[ch]), 32'(t >= l));
    end
    rd(ch, 0, d);
    check($sformatf("one_status_ch%0d", ch), 32'(d), 32'h1);
    wr(ch, 4, 16'h0);
    rd(ch, 4, d);
    check($sformatf("one_count_l_ch%0d", ch), 32'(d), 32'(p & 16'hFFFF));
    rd(ch, 5, d);
    check($sformatf("one_count_h_ch%0d", ch), 32'(d), 32'(p >> 16));
  endtask

  initial begin
    logic [15:0] d;
    int ch, p, s;
    reset = 1'b1;
    bus.address = '0;
    bus.writedata = '0;
    idle();

    vecs.push_back(mk(0, 2, 16'h869F, "rst_ch0_period_l"));
    vecs.push_back(mk(0, 3, 16'h0001, "rst_ch0_period_h"));
    vecs.push_back(mk(0, 0, 16'h0000, "rst_ch0_status"));
    vecs.push_back(mk(0, 1, 16'h0000, "rst_ch0_control"));
    vecs.push_back(mk(0, 6, 16'h0000, "rst_ch0_prescale"));
    vecs.push_back(mk(0, 4, 16'h0000, "rst_ch0_snap_l"));
    vecs.push_back(mk(0, 5, 16'h0000, "rst_ch0_snap_h"));
    vecs.push_back(mk(0, 7, 16'h0000, "rst_ch0_reserved"));
    vecs.push_back(mk(4, 2, 16'h869F, "rst_ch4_period_l"));
    vecs.push_back(mk(4, 3, 16'h0001, "rst_ch4_period_h"));
    vecs.push_back(mk(5, 2, 16'h0000, "rst_ch5_absent"));
    vecs.push_back(mk(7, 3, 16'h0000, "rst_ch7_absent"));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      rd(vecs[i].ch, vecs[i].off, d);
      check(vecs[i].name, 32'(d), 32'(vecs[i].exp));
    end
    check("rst_irq_after_reads", 32'(bus.irq), 32'(0));

    // Directed timing runs; P=0,S=0 makes every clear coincide with a new event.
    run_cont(1, 9, 0, 25);
    run_one(2, 3, 4);
    run_cont(3, 0, 0, 6);

    // Period write while running: RUN drops one cycle later, counter takes the new period.
    do_reset();
    wr(0, 3, 16'h0);
    cyc();
    wr(0, 1, 16'h4);
    cyc(); cyc(); cyc();
    wr(0, 2, 16'd5);
    rd(0, 0, d);
    check("reload_run_still_set", 32'(d), 32'h2);
    rd(0, 0, d);
    check("reload_run_cleared", 32'(d), 32'h0);
    wr(0, 4, 16'h0);
    rd(0, 4, d);
    check("reload_count_l", 32'(d), 32'd5);
    rd(0, 5, d);
    check("reload_count_h", 32'(d), 32'd0);

    // START+STOP together starts; snapshot three cycles in sees 5 minus two ticks.
    wr(0, 1, 16'hC);
    rd(0, 0, d);
    check("startstop_run", 32'(d), 32'h2);
    rd(0, 1, d);
    check("startstop_ctrl_readback", 32'(d), 32'hC);
    wr(0, 5, 16'h0);
    rd(0, 4, d);
    check("snap_running", 32'(d), 32'd3);

    // Absent channel and reserved offset.
    wr(5, 2, 16'h1234);
    rd(5, 2, d);
    check("ch5_write_ignored", 32'(d), 32'h0);
    rd(1, 2, d);
    check("ch5_no_alias_ch1", 32'(d), 32'h869F);
    wr(0, 7, 16'hFFFF);
    rd(0, 7, d);
    check("reserved_reads_zero", 32'(d), 32'h0);

    // Reset while an interrupt is pending.
    do_reset();
    prog(1, 0, 0, 16'h7);
    cyc(); cyc();
    check("midcount_irq_set", 32'(bus.irq), 32'(1));
    do_reset();
    rd(1, 0, d);
    check("midcount_status_cleared", 32'(d), 32'h0);
    rd(1, 2, d);
    check("midcount_period_default", 32'(d), 32'h869F);

    // Randomized periods and prescales.
    for (int it = 0; it < 6; it++) begin
      ch = int'($urandom_range(0, NUM_CH - 1));
      p  = int'($urandom_range(0, 12));
      s  = int'($urandom_range(0, 3));
      if (it % 2 == 0) run_cont(ch, p, s, 3 * (p + 1) * (s + 1) + 2);
      else             run_one(ch, p, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
